// File: rtl/tile_pick_encoder_if.sv
// rtl/tile_pick_encoder_if.sv - tile button / pick strobe bundle between board inputs, encoder and data path
interface tile_pick_encoder_if;
    logic [15:0] btn;
    logic        enable;
    logic [3:0]  position_data;
    logic        A;
    logic        busy;

    // Encoder side: consumes buttons and enable, produces the pick
    modport master (
        input  btn,
        input  enable,
        output position_data,
        output A,
        output busy
    );

    // Board / consumer side
    modport slave (
        output btn,
        output enable,
        input  position_data,
        input  A,
        input  busy
    );
endinterface

// File: rtl/tile_pick_encoder.sv
// rtl/tile_pick_encoder.sv - debounced 16-button tile pick encoder with one-cycle A strobe (optional PICK_REPEAT_BLOCK_EN)
module tile_pick_encoder #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    tile_pick_encoder_if.master  pick_if
);
    localparam int               CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        EMIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    sync1_q, sync2_q;
    logic [15:0]    val_q, val_d;
    logic [3:0]     cand_q, cand_d;
    logic [3:0]     pos_q, pos_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_inc;
    logic [3:0]     cand_w;
    logic [15:0]    btn_s;
    logic           accept_w;
`ifdef PICK_REPEAT_BLOCK_EN
    logic [3:0]     last_q, last_d;
    logic           last_vld_q, last_vld_d;
`endif

    assign btn_s   = sync2_q;
    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    // Two-flop synchronizer for the asynchronous button lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pick_if.btn;
            sync2_q <= sync1_q;
        end
    end

    // Lowest set button wins; scanning downward lets the lowest index overwrite
    always_comb begin
        cand_w = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (btn_s[i]) begin
                cand_w = 4'(i);
            end
        end
    end

    // Repeat filter: a press of the tile just picked is not started from IDLE
    always_comb begin
        accept_w = 1'b1;
`ifdef PICK_REPEAT_BLOCK_EN
        if (last_vld_q && (cand_w == last_q)) begin
            accept_w = 1'b0;
        end
`endif
    end

    // Next-state and datapath updates for the debounce / emit / release sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        cand_d  = cand_q;
        pos_d   = pos_q;
`ifdef PICK_REPEAT_BLOCK_EN
        last_d     = last_q;
        last_vld_d = last_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_if.enable && (btn_s != 16'd0) && accept_w) begin
                    val_d   = btn_s;
                    cand_d  = cand_w;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if ((btn_s == 16'd0) || !pick_if.enable) begin
                    state_d = IDLE;
                end else if (btn_s != val_q) begin
                    // Button set moved while settling: restart on the new value
                    val_d  = btn_s;
                    cand_d = cand_w;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    pos_d   = cand_q;
                    state_d = EMIT;
`ifdef PICK_REPEAT_BLOCK_EN
                    last_d     = cand_q;
                    last_vld_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            EMIT: begin
                cnt_d   = '0;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (btn_s != 16'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any pending pick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
            cand_q  <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            cand_q  <= cand_d;
            pos_q   <= pos_d;
        end
    end

`ifdef PICK_REPEAT_BLOCK_EN
    // Last emitted tile, remembered to suppress an immediate repeat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end
`endif

    assign pick_if.A             = (state_q == EMIT);
    assign pick_if.busy          = (state_q != IDLE);
    assign pick_if.position_data = pos_q;

endmodule

// File: tb/tb_tile_pick_encoder.sv
// tb/tb_tile_pick_encoder.sv - scoreboard bench for tile_pick_encoder
module tb_tile_pick_encoder;
    localparam int DC = 4;

    typedef struct {
        logic [15:0] btn;
        logic [3:0]  pos;
    } vec_t;

    typedef struct {
        logic [3:0] pos;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    logic prev_a;
    exp_t sb[$];
    vec_t vecs[6];

    tile_pick_encoder_if ifc();

    tile_pick_encoder #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk     (clk),
        .rst     (rst),
        .pick_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [3:0] pos, input int at_cyc);
        exp_t e;
        e.pos = pos;
        e.cyc = at_cyc;
        sb.push_back(e);
    endtask

    // One clock: wait for the edge, sample #1 later, score any A strobe
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (ifc.A) begin
            check("a_not_consecutive", int'(prev_a), 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_A actual=1 expected=0 pos=%0d (cyc %0d)", ifc.position_data, cyc);
            end else begin
                e = sb.pop_front();
                check("pick_pos", int'(ifc.position_data), int'(e.pos));
                check("pick_cycle", cyc, e.cyc);
            end
        end
        prev_a = ifc.A;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_sb_empty(input int budget);
        for (int n = 0; n < budget && sb.size() != 0; n++) tick();
        check("missing_A", sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget && ifc.busy; n++) tick();
        check("busy_release_done", int'(ifc.busy), 0);
    endtask

    task automatic press_expect(input logic [15:0] b, input logic [3:0] pos);
        ifc.btn = b;
        push_exp(pos, cyc + 3 + DC);
        wait_sb_empty(30);
        ifc.btn = 16'd0;
        wait_idle(40);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        prev_a = 1'b0;

        vecs[0] = '{btn: 16'h0020, pos: 4'd5};
        vecs[1] = '{btn: 16'h8104, pos: 4'd2};
        vecs[2] = '{btn: 16'h0001, pos: 4'd0};
        vecs[3] = '{btn: 16'h8000, pos: 4'd15};
        vecs[4] = '{btn: 16'hFFFF, pos: 4'd0};
        vecs[5] = '{btn: 16'h0C00, pos: 4'd10};

        rst        = 1'b1;
        ifc.btn    = 16'd0;
        ifc.enable = 1'b0;
        ticks(3);
        check("reset_A", int'(ifc.A), 0);
        check("reset_busy", int'(ifc.busy), 0);
        check("reset_pos", int'(ifc.position_data), 0);
        rst        = 1'b0;
        ifc.enable = 1'b1;
        ticks(2);

        // Table: single presses, strobe at drive+3+DC, busy rises at drive+3
        for (int i = 0; i < 6; i++) begin
            ifc.btn = vecs[i].btn;
            push_exp(vecs[i].pos, cyc + 3 + DC);
            ticks(2);
            check("busy_before_settle", int'(ifc.busy), 0);
            tick();
            check("busy_in_settle", int'(ifc.busy), 1);
            wait_sb_empty(30);
            check("busy_held_after_pick", int'(ifc.busy), 1);
            ifc.btn = 16'd0;
            wait_idle(40);
        end

        // Bounce btn[9] every 2 cycles for 20 cycles, then hold
        for (int i = 0; i < 10; i++) begin
            ifc.btn = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            ticks(2);
        end
        check("bounce_no_pick", sb.size(), 0);
        press_expect(16'h0200, 4'd9);

        // Held with enable low, then enable raised
        ifc.enable = 1'b0;
        ifc.btn    = 16'h0008;
        ticks(5);
        check("disabled_busy_mid", int'(ifc.busy), 0);
        ticks(5);
        check("disabled_busy_end", int'(ifc.busy), 0);
        ifc.enable = 1'b1;
        push_exp(4'd3, cyc + 1 + DC);
        wait_sb_empty(30);
        ifc.btn = 16'd0;
        wait_idle(40);

        // Reset during SETTLE
        ifc.btn = 16'h0040;
        ticks(4);
        check("settle_before_reset", int'(ifc.busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_A", int'(ifc.A), 0);
        check("midrst_busy", int'(ifc.busy), 0);
        check("midrst_pos", int'(ifc.position_data), 0);
        ifc.btn = 16'd0;
        ticks(2);
        rst = 1'b0;
        ticks(20);
        check("after_rst_busy", int'(ifc.busy), 0);
        press_expect(16'h0040, 4'd6);

`ifdef PICK_REPEAT_BLOCK_EN
        press_expect(16'h0080, 4'd7);
        ifc.btn = 16'h0080;
        ticks(15);
        check("repeat_blocked_busy", int'(ifc.busy), 0);
        ifc.btn = 16'd0;
        ticks(5);
        press_expect(16'h1000, 4'd12);
        press_expect(16'h0080, 4'd7);
`else
        press_expect(16'h0080, 4'd7);
        press_expect(16'h0080, 4'd7);
`endif

        ticks(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
